// File: rtl/alu_sequencer_if.sv
// Command and result handshake bundle for alu_sequencer.
// The master issues commands and consumes results; the slave is the sequencer.
interface alu_sequencer_if #(
    parameter int unsigned NIBBLES = 2
);
    localparam int unsigned W = 4 * NIBBLES;

    // Command channel
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         cmd_cin;

    // Result channel
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_cout;
    logic         res_zero;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, res_ready,
        input  cmd_ready, res_valid, res_data, res_cout, res_zero
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, res_ready,
        output cmd_ready, res_valid, res_data, res_cout, res_zero
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle front-end for the external 4-bit combinational ALU.
// A wide command is split into 4-bit slices (LS slice first), carries are chained
// between slices, and one registered wide result with flags is returned.
//
// Timing: the command is latched on the accept edge. Each EXEC edge loads the ALU
// drive for the next slice while capturing alu_y of the slice driven in the
// previous cycle, so EXEC spans NIBBLES+1 edges and res_valid rises exactly
// NIBBLES+1 cycles after accept. The carry into slice k is derived from the
// registered drive and alu_y of slice k-1 on the same edge that loads slice k.
module alu_sequencer #(
    parameter int unsigned NIBBLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    alu_sequencer_if.slave  bus,
    output logic [2:0]      alu_s,
    output logic [3:0]      alu_a,
    output logic [3:0]      alu_b,
    output logic            alu_cin,
    input  logic [3:0]      alu_y
);
    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned KW = (NIBBLES < 2) ? 1 : $clog2(NIBBLES + 1);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            cin_q, cin_d;
    logic [KW-1:0]   k_q, k_d;
    logic [W-1:0]    acc_q, acc_d;

    logic [2:0]      alu_s_q, alu_s_d;
    logic [3:0]      alu_a_q, alu_a_d;
    logic [3:0]      alu_b_q, alu_b_d;
    logic            alu_cin_q, alu_cin_d;

    logic [W-1:0]    res_data_q, res_data_d;
    logic            res_cout_q, res_cout_d;
    logic            res_zero_q, res_zero_d;

    logic [31:0]     kk;
    logic            arith;
    logic            bp3;
    logic            slice_carry;

    assign kk = 32'(k_q);

    // Carry out of the slice currently on the ALU; the ALU itself has no carry output.
    always_comb begin
        arith       = (alu_s_q == 3'b000) || (alu_s_q == 3'b001);
        bp3         = (alu_s_q == 3'b001) ? ~alu_b_q[3] : alu_b_q[3];
        slice_carry = arith & ((alu_a_q[3] & bp3) | ((alu_a_q[3] | bp3) & ~alu_y[3]));
    end

    // Next-state logic: command latch, slice stepping and result commit.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        k_d        = k_q;
        acc_d      = acc_q;
        alu_s_d    = alu_s_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_cin_d  = alu_cin_q;
        res_data_d = res_data_q;
        res_cout_d = res_cout_q;
        res_zero_d = res_zero_q;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    a_d     = bus.cmd_a;
                    b_d     = bus.cmd_b;
                    cin_d   = bus.cmd_cin;
                    alu_s_d = bus.cmd_op;
                    k_d     = '0;
                    state_d = StExec;
                end
            end
            StExec: begin
                // Capture the slice driven during the cycle that is now ending.
                if (kk != 0) begin
                    acc_d[4*(kk-1) +: 4] = alu_y;
                end
                if (kk < NIBBLES) begin
                    alu_a_d   = a_q[4*kk +: 4];
                    alu_b_d   = b_q[4*kk +: 4];
                    alu_cin_d = (kk == 0) ? cin_q : slice_carry;
                    k_d       = k_q + KW'(1);
                end else begin
                    // Result outputs only change here, so they hold between commands.
                    res_data_d = acc_d;
                    res_cout_d = slice_carry;
                    res_zero_d = (acc_d == '0);
                    state_d    = StDone;
                end
            end
            StDone: begin
                if (bus.res_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous reset that discards any in-flight command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            k_q        <= '0;
            acc_q      <= '0;
            alu_s_q    <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_cin_q  <= 1'b0;
            res_data_q <= '0;
            res_cout_q <= 1'b0;
            res_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            alu_s_q    <= alu_s_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_cin_q  <= alu_cin_d;
            res_data_q <= res_data_d;
            res_cout_q <= res_cout_d;
            res_zero_q <= res_zero_d;
        end
    end

    // Output mapping: handshake flags decode straight from the state register.
    always_comb begin
        bus.cmd_ready = (state_q == StIdle);
        bus.res_valid = (state_q == StDone);
        bus.res_data  = res_data_q;
        bus.res_cout  = res_cout_q;
        bus.res_zero  = res_zero_q;
        alu_s         = alu_s_q;
        alu_a         = alu_a_q;
        alu_b         = alu_b_q;
        alu_cin       = alu_cin_q;
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed vector table, hand-written
// multi-cycle sequences (ALU drive order, backpressure, mid-operation reset) and
// random commands checked against a full-width arithmetic reference model.
module tb_alu_sequencer;
    localparam int unsigned NIBBLES = 2;
    localparam int unsigned W       = 4 * NIBBLES;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] alu_s;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_y;
    logic       alu_cin;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_sequencer_if #(.NIBBLES(NIBBLES)) bus ();

    alu_sequencer #(.NIBBLES(NIBBLES)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .alu_s   (alu_s),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_cin (alu_cin),
        .alu_y   (alu_y)
    );

    // Behavioural model of the external 4-bit ALU.
    always_comb begin
        case (alu_s)
            3'd0:    alu_y = alu_a + alu_b + {3'b000, alu_cin};
            3'd1:    alu_y = alu_a + ~alu_b + {3'b000, alu_cin};
            3'd2:    alu_y = alu_b;
            3'd3:    alu_y = alu_a;
            3'd4:    alu_y = alu_a & alu_b;
            3'd5:    alu_y = alu_a | alu_b;
            3'd6:    alu_y = ~alu_a;
            default: alu_y = alu_a ^ alu_b;
        endcase
    end

    // Whole-word reference: {carry, data}.
    function automatic logic [W:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic cin);
        logic [W:0] r;
        case (op)
            3'd0:    r = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            3'd1:    r = {1'b0, a} + {1'b0, ~b} + (W+1)'(cin);
            3'd2:    r = {1'b0, b};
            3'd3:    r = {1'b0, a};
            3'd4:    r = {1'b0, a & b};
            3'd5:    r = {1'b0, a | b};
            3'd6:    r = {1'b0, ~a};
            default: r = {1'b0, a ^ b};
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Issue one command, wait for the result, hold it for 'hold' cycles, then accept.
    task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input int hold, output logic [W-1:0] d,
                           output logic co, output logic z);
        int lat;
        @(negedge clk);
        check("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_cin   = cin;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        // Scribble on operands during EXEC; they must be ignored.
        bus.cmd_a     = W'($urandom);
        bus.cmd_b     = W'($urandom);
        lat = 0;
        while (!bus.res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, NIBBLES + 1);
        d  = bus.res_data;
        co = bus.res_cout;
        z  = bus.res_zero;
        repeat (hold) @(negedge clk);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("res_valid_drop", bus.res_valid, 0);
        check("cmd_ready_back", bus.cmd_ready, 1);
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] data;
        logic         cout;
        logic         zero;
    } vec_t;

    vec_t vecs[13];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "simulation timeout");
    end

    initial begin : main
        logic [W-1:0] d;
        logic [W-1:0] held;
        logic         co;
        logic         z;
        logic [W:0]   m;
        int           lat;

        vecs[0]  = '{3'd0, 8'h3C, 8'h4F, 1'b0, 8'h8B, 1'b0, 1'b0};
        vecs[1]  = '{3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[2]  = '{3'd1, 8'h50, 8'h21, 1'b1, 8'h2F, 1'b1, 1'b0};
        vecs[3]  = '{3'd1, 8'h21, 8'h50, 1'b1, 8'hD1, 1'b0, 1'b0};
        vecs[4]  = '{3'd7, 8'hA5, 8'hFF, 1'b0, 8'h5A, 1'b0, 1'b0};
        vecs[5]  = '{3'd6, 8'h0F, 8'h33, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[6]  = '{3'd2, 8'h77, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[7]  = '{3'd3, 8'h9C, 8'h11, 1'b1, 8'h9C, 1'b0, 1'b0};
        vecs[8]  = '{3'd4, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0};
        vecs[9]  = '{3'd5, 8'h0F, 8'h30, 1'b0, 8'h3F, 1'b0, 1'b0};
        vecs[10] = '{3'd0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[11] = '{3'd1, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[12] = '{3'd7, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_cin   = 1'b0;
        bus.res_ready = 1'b0;

        // Asynchronous reset takes effect before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_res_flags", {bus.res_cout, bus.res_zero}, 0);
        check("rst_alu", {alu_s, alu_a, alu_b, alu_cin}, 0);
        @(negedge clk);
        rst = 1'b0;

        // ALU drive order: slice C/F with cin 0, then 3/4 with the chained carry.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd0;
        bus.cmd_a     = 8'h3C;
        bus.cmd_b     = 8'h4F;
        bus.cmd_cin   = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("cmd_ready_exec", bus.cmd_ready, 0);
        @(negedge clk);
        check("drive0", {alu_s, alu_a, alu_b, alu_cin}, {3'd0, 4'hC, 4'hF, 1'b0});
        @(negedge clk);
        check("drive1", {alu_s, alu_a, alu_b, alu_cin}, {3'd0, 4'h3, 4'h4, 1'b1});
        check("not_valid_early", bus.res_valid, 0);
        @(negedge clk);
        check("valid_at_3", bus.res_valid, 1);
        check("drive_data", bus.res_data, 8'h8B);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("drive_hs_idle", bus.cmd_ready, 1);
        check("hold_after_hs", bus.res_data, 8'h8B);

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, i % 3, d, co, z);
            check($sformatf("vec%0d_data", i), d, vecs[i].data);
            check($sformatf("vec%0d_cout", i), co, vecs[i].cout);
            check($sformatf("vec%0d_zero", i), z, vecs[i].zero);
        end

        // Backpressure: result held stable for 5 cycles, a command pulse is ignored.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd0;
        bus.cmd_a     = 8'h12;
        bus.cmd_b     = 8'h34;
        bus.cmd_cin   = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        lat = 0;
        while (!bus.res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp_latency", lat, NIBBLES + 1);
        held = bus.res_data;
        check("bp_data", held, 8'h46);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_hold", bus.res_valid, 1);
            check("bp_data_hold", bus.res_data, held);
            check("bp_cmd_ready", bus.cmd_ready, 0);
            bus.cmd_valid = (i == 1);
            bus.cmd_op    = 3'd7;
            bus.cmd_a     = 8'hFF;
            bus.cmd_b     = 8'h00;
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("bp_release_valid", bus.res_valid, 0);
        check("bp_release_ready", bus.cmd_ready, 1);
        check("bp_release_data", bus.res_data, 8'h46);
        repeat (4) @(negedge clk);
        check("bp_no_ghost", bus.res_valid, 0);
        run_cmd(3'd0, 8'h10, 8'h20, 1'b0, 0, d, co, z);
        check("bp_next_data", d, 8'h30);

        // Reset during EXEC after the first slice has been captured.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd0;
        bus.cmd_a     = 8'h3C;
        bus.cmd_b     = 8'h4F;
        bus.cmd_cin   = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_cmd_ready", bus.cmd_ready, 1);
        check("mid_rst_res_valid", bus.res_valid, 0);
        check("mid_rst_res_data", bus.res_data, 0);
        check("mid_rst_alu", {alu_s, alu_a, alu_b, alu_cin}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_rst_stays_idle", bus.res_valid, 0);
        run_cmd(3'd0, 8'h01, 8'h01, 1'b0, 1, d, co, z);
        check("mid_rst_next_data", d, 8'h02);
        check("mid_rst_next_flags", {co, z}, 0);

        // Random commands against the reference model.
        for (int i = 0; i < 120; i++) begin
            logic [2:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         cin;
            op  = 3'($urandom);
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            m   = model(op, a, b, cin);
            run_cmd(op, a, b, cin, $urandom_range(0, 3), d, co, z);
            check($sformatf("rnd%0d_data", i), d, m[W-1:0]);
            check($sformatf("rnd%0d_cout", i), co, m[W]);
            check($sformatf("rnd%0d_zero", i), z, (m[W-1:0] == '0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
